// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI mode-0 slave front end for a 32x8 register file.
// Decodes 16-bit frames (RW, addr, data) into register writes and MISO read-back.
`timescale 1ns/1ps

module spi_reg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              frame_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;

  logic [1:0]        state;
  logic [4:0]        bit_cnt;
  logic [7:0]        rx_shift;
  logic [DATA_W-1:0] tx_shift;
  logic              rw;
  logic              load_tx;

  logic       sclk_s;
  logic       cs_s;
  logic       mosi_s;
  logic       sclk_rise;
  logic       sclk_fall;
  logic       cs_fall;
  logic       cs_rise;
  logic [7:0] byte_next;
  logic       unused_byte_bits;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;
  assign cs_rise   = cs_s & ~cs_prev;

  // Byte completed by the current SCLK rise: 7 bits already shifted plus MOSI now.
  assign byte_next        = {rx_shift[6:0], mosi_s};
  assign unused_byte_bits = ^byte_next[6:5];

  assign busy     = (state != ST_IDLE);
  assign spi_miso = (state == ST_DATA) & rw & tx_shift[DATA_W-1];

  // CS_N chain resets low so a frame in flight at reset needs a fresh fall to restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 5'd0;
      rx_shift  <= 8'd0;
      tx_shift  <= '0;
      rw        <= 1'b0;
      load_tx   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      frame_err <= 1'b0;
      load_tx   <= 1'b0;

      // mem_addr changed on the 8th rise, so mem_rdata is valid one clk later.
      if (load_tx) begin
        tx_shift <= mem_rdata;
      end else if (sclk_fall && state == ST_DATA && rw &&
                   bit_cnt >= 5'd9 && bit_cnt <= 5'd15) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end

      case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state    <= ST_CMD;
            bit_cnt  <= 5'd0;
            rx_shift <= 8'd0;
          end
        end
        ST_CMD: begin
          if (cs_rise) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else if (sclk_rise) begin
            bit_cnt  <= bit_cnt + 5'd1;
            rx_shift <= byte_next;
            if (bit_cnt == 5'd7) begin
              state    <= ST_DATA;
              rw       <= byte_next[7];
              mem_addr <= byte_next[ADDR_W-1:0];
              load_tx  <= byte_next[7];
            end
          end
        end
        ST_DATA: begin
          if (cs_rise) begin
            state     <= ST_IDLE;
            frame_err <= 1'b1;
          end else if (sclk_rise) begin
            bit_cnt  <= bit_cnt + 5'd1;
            rx_shift <= byte_next;
            if (bit_cnt == 5'd15) begin
              state <= ST_DONE;
              if (!rw) begin
                mem_wdata <= byte_next[DATA_W-1:0];
                mem_we    <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          // Bit counter stays at 16; further SCLK edges are ignored.
          if (cs_rise) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - self-checking bench for spi_reg_ctrl.
// Table-driven frames, hand-written reset/abort sequences and random frames vs a frame-level model.
`timescale 1ns/1ps

module tb_spi_reg_ctrl;

  localparam int HALF = 6;  // SCLK half period in clk cycles (12x oversampling)

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
  logic       busy;
  logic       frame_err;

  spi_reg_ctrl #(.SYNC_STAGES(2), .ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Register-file stand-in driven by the DUT's memory port.
  logic [7:0] regfile [32];
  int we_cnt  = 0;
  int err_cnt = 0;
  assign mem_rdata = regfile[mem_addr];

  always @(posedge clk) begin
    if (mem_we) begin
      regfile[mem_addr] = mem_wdata;
      we_cnt++;
    end
    if (frame_err) err_cnt++;
  end

  // Frame-level reference model.
  logic [7:0] model_regs [32];
  logic [4:0] model_addr;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] word;
    int          nbits;
    logic        exp_err;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [7:0]  exp_data;  // write data for writes, returned byte for reads
  } vec_t;

  // Drives one frame of nbits SCLK pulses and captures MISO just before each rise.
  task automatic frame(input logic [15:0] w, input int nbits,
                       output logic [7:0] rbyte, output logic miso_bad,
                       output logic busy_mid);
    rbyte    = 8'h00;
    miso_bad = 1'b0;
    busy_mid = 1'b0;
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? w[15-i] : 1'($urandom);
      repeat (HALF) @(negedge clk);
      if (i >= 8 && i < 16) rbyte[15-i] = spi_miso;
      else if (spi_miso !== 1'b0) miso_bad = 1'b1;
      if (i == 3) busy_mid = busy;
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_and_check(input string tag, input logic [15:0] w, input int nbits,
                               input logic exp_err, input logic exp_we,
                               input logic [4:0] exp_addr, input logic [7:0] exp_data);
    int         we0, err0;
    logic [7:0] rbyte;
    logic       miso_bad, busy_mid;
    we0  = we_cnt;
    err0 = err_cnt;
    frame(w, nbits, rbyte, miso_bad, busy_mid);
    chk({tag, " we_pulses"}, we_cnt - we0, {31'd0, exp_we});
    chk({tag, " frame_err"}, err_cnt - err0, {31'd0, exp_err});
    chk({tag, " mem_addr"}, mem_addr, exp_addr);
    chk({tag, " miso_idle"}, miso_bad, 0);
    chk({tag, " busy_mid"}, busy_mid, (nbits > 3) ? 1 : 0);
    chk({tag, " busy_end"}, busy, 0);
    if (exp_we) chk({tag, " mem_wdata"}, mem_wdata, exp_data);
    if (w[15] && nbits >= 16) chk({tag, " read_byte"}, rbyte, exp_data);
  endtask

  // Applies the frame rules to the model and returns what the DUT should do.
  task automatic model_frame(input logic [15:0] w, input int nbits,
                             output logic e_err, output logic e_we,
                             output logic [4:0] e_addr, output logic [7:0] e_data);
    e_err  = (nbits < 16);
    e_we   = (nbits >= 16) && !w[15];
    e_addr = (nbits >= 8) ? w[12:8] : model_addr;
    e_data = w[15] ? model_regs[w[12:8]] : w[7:0];
    if (e_we) model_regs[w[12:8]] = w[7:0];
    model_addr = e_addr;
  endtask

  vec_t vecs [11];

  initial begin
    logic [7:0] rbyte;
    logic       miso_bad, busy_mid;
    logic       e_err, e_we;
    logic [4:0] e_addr;
    logic [7:0] e_data;
    logic [15:0] w;
    int          nb, we0, err0;

    for (int i = 0; i < 32; i++) begin
      regfile[i]    = 8'h00;
      model_regs[i] = 8'h00;
    end
    model_addr = 5'd0;

    vecs[0]  = '{16'h03A5, 16, 1'b0, 1'b1, 5'd3,  8'hA5};
    vecs[1]  = '{16'h8300, 16, 1'b0, 1'b0, 5'd3,  8'hA5};
    vecs[2]  = '{16'h1F3C, 16, 1'b0, 1'b1, 5'd31, 8'h3C};
    vecs[3]  = '{16'h9F00, 16, 1'b0, 1'b0, 5'd31, 8'h3C};
    vecs[4]  = '{16'h6A11, 16, 1'b0, 1'b1, 5'd10, 8'h11};
    vecs[5]  = '{16'hEA00, 16, 1'b0, 1'b0, 5'd10, 8'h11};
    vecs[6]  = '{16'h0455, 11, 1'b1, 1'b0, 5'd4,  8'h55};
    vecs[7]  = '{16'h8400, 16, 1'b0, 1'b0, 5'd4,  8'h00};
    vecs[8]  = '{16'h0242, 20, 1'b0, 1'b1, 5'd2,  8'h42};
    vecs[9]  = '{16'h8200, 20, 1'b0, 1'b0, 5'd2,  8'h42};
    vecs[10] = '{16'h0177, 5,  1'b1, 1'b0, 5'd2,  8'h77};

    rst = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst mem_we", mem_we, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst busy", busy, 0);
    chk("rst miso", spi_miso, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post-rst frame_err count", err_cnt, 0);

    foreach (vecs[k]) begin
      run_and_check($sformatf("vec%0d", k), vecs[k].word, vecs[k].nbits,
                    vecs[k].exp_err, vecs[k].exp_we, vecs[k].exp_addr, vecs[k].exp_data);
      if (vecs[k].exp_we) model_regs[vecs[k].word[12:8]] = vecs[k].word[7:0];
      if (vecs[k].nbits >= 8) model_addr = vecs[k].word[12:8];
    end

    // Reset in the middle of a write frame, after 12 bits.
    we0  = we_cnt;
    err0 = err_cnt;
    w    = 16'h0477;
    @(negedge clk) spi_cs_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      spi_mosi = w[15-i];
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst mem_addr", mem_addr, 0);
    chk("midrst miso", spi_miso, 0);
    rst = 1'b0;
    for (int i = 12; i < 16; i++) begin
      spi_mosi = w[15-i];
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sclk = 1'b0;
    end
    chk("midrst busy after pulses", busy, 0);
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst we_pulses", we_cnt - we0, 0);
    chk("midrst frame_err", err_cnt - err0, 0);
    model_addr = 5'd0;
    model_frame(16'h8300, 16, e_err, e_we, e_addr, e_data);
    run_and_check("after-rst read", 16'h8300, 16, e_err, e_we, e_addr, e_data);
    chk("after-rst data A5", e_data, 8'hA5);

    // Random frames against the model.
    for (int n = 0; n < 30; n++) begin
      w  = 16'($urandom);
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 20) : 16;
      model_frame(w, nb, e_err, e_we, e_addr, e_data);
      run_and_check($sformatf("rnd%0d", n), w, nb, e_err, e_we, e_addr, e_data);
    end

    // Whole register file matches the model.
    for (int i = 0; i < 32; i++) chk($sformatf("regfile[%0d]", i), regfile[i], model_regs[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
